// File: rtl/wb_burst_drain.sv
// rtl/wb_burst_drain.sv - write-back burst master draining header+line records from the show-ahead fifo
// Each record becomes one LINE_WORDS-beat valid/ready write burst at the header's word-aligned address.
module wb_burst_drain #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              fifo_empty_i,
  output logic              fifo_pop_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_last_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  bursts_o
);

  localparam int                BEAT_W    = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  base_q, base_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   bursts_q, bursts_d;

  logic               pop_c;
  logic               hs;
  logic [BEAT_W-1:0]  beat_inc;
  logic [DATA_W-1:0]  beat_addr;

  assign hs        = valid_q & mem_ready_i;
  assign beat_inc  = beat_q + BEAT_W'(1);
  assign beat_addr = base_q + DATA_W'({beat_q, 2'b00});

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    beat_d   = beat_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    last_d   = last_q;
    bursts_d = bursts_q;
    pop_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Any word seen here is taken as a header; framing is not checked.
        if (!fifo_empty_i) begin
          pop_c   = 1'b1;
          base_d  = {fifo_data_i[DATA_W-1:2], 2'b00};
          beat_d  = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (!fifo_empty_i) begin
          pop_c   = 1'b1;
          data_d  = fifo_data_i;
          addr_d  = beat_addr;
          valid_d = 1'b1;
          last_d  = (beat_q == LAST_BEAT);
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        if (hs) begin
          if (last_q) begin
            bursts_d = bursts_q + CNT_W'(1);
            valid_d  = 1'b0;
            last_d   = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            beat_d = beat_inc;
            addr_d = addr_q + DATA_W'(4);
            // Refill in the handshake cycle so beats stay back-to-back.
            if (!fifo_empty_i) begin
              pop_c  = 1'b1;
              data_d = fifo_data_i;
              last_d = (beat_inc == LAST_BEAT);
            end else begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              state_d = ST_FETCH;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      beat_q   <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      bursts_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      last_q   <= last_d;
      bursts_q <= bursts_d;
    end
  end

  // Gated by reset so the fifo is never consumed while the block is held in reset.
  assign fifo_pop_o  = pop_c & rstn_i;
  assign mem_valid_o = valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign mem_last_o  = last_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign bursts_o    = bursts_q;

endmodule

// File: tb/tb_wb_burst_drain.sv
// tb/tb_wb_burst_drain.sv - self-checking bench for wb_burst_drain
module tb_wb_burst_drain;

  localparam int DW = 32;
  localparam int LW = 4;
  localparam int CW = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_empty_i;
  logic          fifo_pop_o;
  logic          mem_valid_o;
  logic          mem_ready_i;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_last_o;
  logic          busy_o;
  logic [CW-1:0] bursts_o;

  always #5 clk = ~clk;

  wb_burst_drain #(.DATA_W(DW), .LINE_WORDS(LW), .CNT_W(CW)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .fifo_data_i (fifo_data_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_pop_o  (fifo_pop_o),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_last_o  (mem_last_o),
    .busy_o      (busy_o),
    .bursts_o    (bursts_o)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] all_words[$];
  int          rd_idx = 0;
  beat_t       exp_q[$];
  int          np = 0;
  int          phase = 0;
  logic [31:0] p_base = 32'd0;
  int          model_bursts = 0;
  logic [31:0] hs_addr[$];
  logic [31:0] hs_data[$];
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [31:0] prev_a = 32'd0, prev_d = 32'd0;
  logic        s_pop, s_valid, s_ready, s_last, s_busy;
  logic [31:0] s_addr, s_data;

  logic [31:0] t1_pop  [7] = '{1, 1, 1, 1, 1, 0, 0};
  logic [31:0] t1_busy [7] = '{0, 1, 1, 1, 1, 1, 0};
  logic [31:0] t1_valid[7] = '{0, 0, 1, 1, 1, 1, 0};
  logic [31:0] t1_addr [7] = '{0, 0, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 0};
  logic [31:0] t1_data [7] = '{0, 0, 32'hA, 32'hB, 32'hC, 32'hD, 0};
  logic [31:0] t1_last [7] = '{0, 0, 0, 0, 0, 1, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Record model: words are framed as header + LW data words from the last reset point.
  function automatic void parse(input logic [31:0] w);
    beat_t b;
    if (phase == 0) begin
      p_base = {w[31:2], 2'b00};
    end else begin
      b.addr = p_base + 32'(4 * (phase - 1));
      b.data = w;
      b.last = (phase == LW);
      exp_q.push_back(b);
    end
    phase = (phase == LW) ? 0 : phase + 1;
  endfunction

  function automatic void drive_fifo();
    if (rd_idx < all_words.size()) begin
      fifo_empty_i = 1'b0;
      fifo_data_i  = all_words[rd_idx];
    end else begin
      fifo_empty_i = 1'b1;
      fifo_data_i  = 32'd0;
    end
  endfunction

  task automatic push_word(input logic [31:0] w);
    all_words.push_back(w);
    drive_fifo();
  endtask

  task automatic compare_cycle();
    beat_t b;
    if (!rstn_i) begin
      chk("rst_valid", 32'(mem_valid_o), 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_data", mem_data_o, 32'd0);
      chk("rst_last", 32'(mem_last_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_bursts", 32'(bursts_o), 32'd0);
      chk("rst_pop", 32'(fifo_pop_o), 32'd0);
      exp_q.delete();
      phase        = 0;
      model_bursts = 0;
      np           = rd_idx;
      prev_v       = 1'b0;
    end else begin
      while (np < all_words.size()) begin
        parse(all_words[np]);
        np++;
      end
      chk("bursts", 32'(bursts_o), 32'(model_bursts));
      if (fifo_empty_i) chk("pop_while_empty", 32'(fifo_pop_o), 32'd0);
      if (mem_valid_o && !mem_ready_i) chk("pop_without_hs", 32'(fifo_pop_o), 32'd0);
      if (mem_valid_o) chk("busy_with_valid", 32'(busy_o), 32'd1);
      if (prev_v && !prev_r) begin
        chk("stall_valid", 32'(mem_valid_o), 32'd1);
        chk("stall_addr", mem_addr_o, prev_a);
        chk("stall_data", mem_data_o, prev_d);
        chk("stall_last", 32'(mem_last_o), 32'(prev_l));
      end
      if (mem_valid_o && mem_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(mem_addr_o), 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          chk("beat_addr", mem_addr_o, b.addr);
          chk("beat_data", mem_data_o, b.data);
          chk("beat_last", 32'(mem_last_o), 32'(b.last));
          if (b.last) model_bursts++;
        end
      end
      prev_v = mem_valid_o;
      prev_r = mem_ready_i;
      prev_a = mem_addr_o;
      prev_d = mem_data_o;
      prev_l = mem_last_o;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_pop   = fifo_pop_o;
    s_valid = mem_valid_o;
    s_ready = mem_ready_i;
    s_addr  = mem_addr_o;
    s_data  = mem_data_o;
    s_last  = mem_last_o;
    s_busy  = busy_o;
    if (s_valid && s_ready && rstn_i) begin
      hs_addr.push_back(s_addr);
      hs_data.push_back(s_data);
    end
    @(posedge clk);
    #1;
    if (s_pop) rd_idx++;
    drive_fifo();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (!busy_o && rd_idx == all_words.size()) break;
      tick();
    end
    chk(name, (busy_o || rd_idx != all_words.size()) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic wait_beat(input string name, input logic [31:0] addr);
    for (int i = 0; i < 60; i++) begin
      if (mem_valid_o && mem_addr_o == addr) break;
      tick();
    end
    chk(name, mem_addr_o, addr);
  endtask

  initial begin
    rstn_i      = 1'b0;
    mem_ready_i = 1'b1;
    drive_fifo();
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    // Reset with a non-empty fifo, then a single unstalled burst.
    push_word(32'h0000_1003);
    push_word(32'hA);
    push_word(32'hB);
    push_word(32'hC);
    push_word(32'hD);
    repeat (3) tick();
    chk("rst_hold_pop", 32'(fifo_pop_o), 32'd0);
    rstn_i = 1'b1;
    #1;
    chk("pop_on_release", 32'(fifo_pop_o), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t1_pop", 32'(s_pop), t1_pop[i]);
      chk("t1_busy", 32'(s_busy), t1_busy[i]);
      chk("t1_valid", 32'(s_valid), t1_valid[i]);
      if (t1_valid[i] != 0) begin
        chk("t1_addr", s_addr, t1_addr[i]);
        chk("t1_data", s_data, t1_data[i]);
        chk("t1_last", 32'(s_last), t1_last[i]);
      end
    end
    chk("t1_bursts", 32'(bursts_o), 32'd1);
    chk("t1_fifo_empty", 32'(fifo_empty_i), 32'd1);

    // Backpressure on beat 2.
    push_word(32'h0000_1003);
    push_word(32'hA);
    push_word(32'hB);
    push_word(32'hC);
    push_word(32'hD);
    wait_beat("t2_reach_beat2", 32'h1004);
    mem_ready_i = 1'b0;
    repeat (3) begin
      tick();
      chk("t2_stall_valid", 32'(s_valid), 32'd1);
      chk("t2_stall_addr", s_addr, 32'h1004);
      chk("t2_stall_data", s_data, 32'hB);
      chk("t2_stall_pop", 32'(s_pop), 32'd0);
    end
    mem_ready_i = 1'b1;
    wait_idle("t2_idle");
    chk("t2_bursts", 32'(bursts_o), 32'd2);

    // Fifo underflow mid-burst.
    hs_addr.delete();
    hs_data.delete();
    push_word(32'h0000_1000);
    push_word(32'h11);
    push_word(32'h22);
    repeat (5) tick();
    chk("t3_gap_valid", 32'(mem_valid_o), 32'd0);
    chk("t3_gap_busy", 32'(busy_o), 32'd1);
    push_word(32'h33);
    push_word(32'h44);
    wait_idle("t3_idle");
    chk("t3_beats", 32'(hs_addr.size()), 32'd4);
    if (hs_addr.size() == 4) begin
      chk("t3_resume_addr", hs_addr[2], 32'h1008);
      chk("t3_resume_data", hs_data[2], 32'h33);
    end
    chk("t3_bursts", 32'(bursts_o), 32'd3);

    // Address wrap across the top of the address space.
    hs_addr.delete();
    hs_data.delete();
    push_word(32'hFFFF_FFF8);
    push_word(32'h1);
    push_word(32'h2);
    push_word(32'h3);
    push_word(32'h4);
    wait_idle("t4_idle");
    chk("t4_beats", 32'(hs_addr.size()), 32'd4);
    if (hs_addr.size() == 4) begin
      chk("t4_addr0", hs_addr[0], 32'hFFFF_FFF8);
      chk("t4_addr1", hs_addr[1], 32'hFFFF_FFFC);
      chk("t4_addr2", hs_addr[2], 32'h0000_0000);
      chk("t4_addr3", hs_addr[3], 32'h0000_0004);
    end
    chk("t4_bursts", 32'(bursts_o), 32'd4);

    // Reset during beat 2; leftover word 0x3 becomes the next header.
    push_word(32'h0000_2000);
    push_word(32'h1);
    push_word(32'h2);
    push_word(32'h3);
    push_word(32'h4);
    wait_beat("t5_reach_beat2", 32'h2004);
    #1;
    rstn_i = 1'b0;
    #1;
    chk("t5_async_valid", 32'(mem_valid_o), 32'd0);
    chk("t5_async_addr", mem_addr_o, 32'd0);
    chk("t5_async_data", mem_data_o, 32'd0);
    chk("t5_async_busy", 32'(busy_o), 32'd0);
    chk("t5_async_bursts", 32'(bursts_o), 32'd0);
    chk("t5_async_pop", 32'(fifo_pop_o), 32'd0);
    repeat (2) tick();
    rstn_i = 1'b1;
    hs_addr.delete();
    hs_data.delete();
    push_word(32'h9);
    push_word(32'hA);
    push_word(32'hB);
    wait_idle("t5_idle");
    chk("t5_beats", 32'(hs_addr.size()), 32'd4);
    if (hs_addr.size() == 4) begin
      chk("t5_addr0", hs_addr[0], 32'h0);
      chk("t5_data0", hs_data[0], 32'h4);
      chk("t5_data1", hs_data[1], 32'h9);
      chk("t5_addr3", hs_addr[3], 32'hC);
    end
    chk("t5_bursts", 32'(bursts_o), 32'd1);
    repeat (2) tick();
    chk("exp_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
